// File: rtl/machine_state_dumper.sv
// Post-run read-out engine: streams every register, then a window of data-memory words, over a valid/ready channel.
// Registers take 2 cycles/word, memory words 3 cycles/word; outValid and the word are held while outReady is low.
module machine_state_dumper #(
  parameter int          NUM_REGS  = 32,
  parameter int          MEM_WORDS = 64,
  parameter logic [31:0] MEM_BASE  = 32'h0
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        start,
  input  logic        abort,
  output logic        holdCpu,
  output logic        busy,
  output logic        done,
  output logic [4:0]  dbgRegAddr,
  input  logic [31:0] dbgRegData,
  output logic [31:0] dbgMemAddr,
  output logic        dbgMemRead,
  input  logic [31:0] dbgMemData,
  output logic        outValid,
  input  logic        outReady,
  output logic [31:0] outData,
  output logic        outIsMem,
  output logic [7:0]  outIndex
);

  typedef enum logic [2:0] {
    IDLE,
    REG_FETCH,
    REG_OUT,
    MEM_ADDR,
    MEM_CAPTURE,
    MEM_OUT,
    DONE
  } state_e;

  localparam logic [7:0] REG_LAST = 8'(NUM_REGS - 1);
  localparam logic [7:0] MEM_LAST = (MEM_WORDS > 0) ? 8'(MEM_WORDS - 1) : 8'd0;

  state_e      state_q;
  logic [7:0]  idx_q;
  logic        hold_q;
  logic        busy_q;
  logic        done_q;
  logic [4:0]  reg_addr_q;
  logic [31:0] mem_addr_q;
  logic        mem_rd_q;
  logic        out_vld_q;
  logic [31:0] out_dat_q;
  logic        out_is_mem_q;
  logic [7:0]  out_idx_q;

  logic [7:0]  idx_inc_d;
  logic [31:0] mem_addr_inc_d;

  assign idx_inc_d      = idx_q + 8'd1;
  // Byte address of the next memory word; wraps modulo 2^32.
  assign mem_addr_inc_d = MEM_BASE + {22'd0, idx_inc_d, 2'b00};

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q      <= IDLE;
      idx_q        <= 8'd0;
      hold_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      reg_addr_q   <= 5'd0;
      mem_addr_q   <= 32'd0;
      mem_rd_q     <= 1'b0;
      out_vld_q    <= 1'b0;
      out_dat_q    <= 32'd0;
      out_is_mem_q <= 1'b0;
      out_idx_q    <= 8'd0;
    end else if (abort) begin
      state_q    <= IDLE;
      idx_q      <= 8'd0;
      hold_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      reg_addr_q <= 5'd0;
      mem_addr_q <= 32'd0;
      mem_rd_q   <= 1'b0;
      out_vld_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q    <= REG_FETCH;
            idx_q      <= 8'd0;
            reg_addr_q <= 5'd0;
            hold_q     <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        REG_FETCH: begin
          out_dat_q    <= dbgRegData;
          out_is_mem_q <= 1'b0;
          out_idx_q    <= idx_q;
          out_vld_q    <= 1'b1;
          state_q      <= REG_OUT;
        end
        REG_OUT: begin
          if (outReady) begin
            out_vld_q <= 1'b0;
            if (idx_q == REG_LAST) begin
              idx_q      <= 8'd0;
              reg_addr_q <= 5'd0;
              if (MEM_WORDS > 0) begin
                mem_addr_q <= MEM_BASE;
                mem_rd_q   <= 1'b1;
                state_q    <= MEM_ADDR;
              end else begin
                done_q  <= 1'b1;
                state_q <= DONE;
              end
            end else begin
              idx_q      <= idx_inc_d;
              reg_addr_q <= idx_inc_d[4:0];
              state_q    <= REG_FETCH;
            end
          end
        end
        MEM_ADDR: begin
          state_q <= MEM_CAPTURE;
        end
        MEM_CAPTURE: begin
          out_dat_q    <= dbgMemData;
          out_is_mem_q <= 1'b1;
          out_idx_q    <= idx_q;
          out_vld_q    <= 1'b1;
          mem_rd_q     <= 1'b0;
          state_q      <= MEM_OUT;
        end
        MEM_OUT: begin
          if (outReady) begin
            out_vld_q <= 1'b0;
            if (idx_q == MEM_LAST) begin
              idx_q      <= 8'd0;
              mem_addr_q <= 32'd0;
              done_q     <= 1'b1;
              state_q    <= DONE;
            end else begin
              idx_q      <= idx_inc_d;
              mem_addr_q <= mem_addr_inc_d;
              mem_rd_q   <= 1'b1;
              state_q    <= MEM_ADDR;
            end
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          hold_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign holdCpu    = hold_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign dbgRegAddr = reg_addr_q;
  assign dbgMemAddr = mem_addr_q;
  assign dbgMemRead = mem_rd_q;
  assign outValid   = out_vld_q;
  assign outData    = out_dat_q;
  assign outIsMem   = out_is_mem_q;
  assign outIndex   = out_idx_q;

endmodule

// File: tb/tb_machine_state_dumper.sv
// Directed bench: a 4-word memory window instance and a register-only instance share stimulus and are scoreboarded against a vector table.
module tb_machine_state_dumper;

  logic        clk;
  logic        resetN;
  logic        start;
  logic        abort;
  logic        outReady;

  logic        holdCpu, busy, done, dbgMemRead, outValid, outIsMem;
  logic [4:0]  dbgRegAddr;
  logic [31:0] dbgRegData, dbgMemAddr, dbgMemData, outData;
  logic [7:0]  outIndex;

  logic        holdCpu0, busy0, done0, dbgMemRead0, outValid0, outIsMem0;
  logic [4:0]  dbgRegAddr0;
  logic [31:0] dbgRegData0, dbgMemAddr0, outData0;
  logic [7:0]  outIndex0;
  logic [31:0] zero_word;

  logic [31:0] regs [32];
  logic [31:0] mem  [16];
  logic [31:0] mem_rd_q;

  typedef struct {
    logic        is_mem;
    logic [7:0]  index;
    logic [31:0] dat;
  } vec_t;
  vec_t tbl [36];

  int n_checks;
  int n_fail;

  machine_state_dumper #(.NUM_REGS(32), .MEM_WORDS(4), .MEM_BASE(32'h0)) dut (
    .clk(clk), .resetN(resetN), .start(start), .abort(abort),
    .holdCpu(holdCpu), .busy(busy), .done(done),
    .dbgRegAddr(dbgRegAddr), .dbgRegData(dbgRegData),
    .dbgMemAddr(dbgMemAddr), .dbgMemRead(dbgMemRead), .dbgMemData(dbgMemData),
    .outValid(outValid), .outReady(outReady), .outData(outData),
    .outIsMem(outIsMem), .outIndex(outIndex)
  );

  machine_state_dumper #(.NUM_REGS(32), .MEM_WORDS(0), .MEM_BASE(32'h0)) dut0 (
    .clk(clk), .resetN(resetN), .start(start), .abort(abort),
    .holdCpu(holdCpu0), .busy(busy0), .done(done0),
    .dbgRegAddr(dbgRegAddr0), .dbgRegData(dbgRegData0),
    .dbgMemAddr(dbgMemAddr0), .dbgMemRead(dbgMemRead0), .dbgMemData(zero_word),
    .outValid(outValid0), .outReady(outReady), .outData(outData0),
    .outIsMem(outIsMem0), .outIndex(outIndex0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign zero_word   = 32'd0;
  assign dbgRegData  = regs[dbgRegAddr];
  assign dbgRegData0 = regs[dbgRegAddr0];
  assign dbgMemData  = mem_rd_q;

  // Synchronous-read data memory: data appears the cycle after the address.
  always @(posedge clk) begin
    if (dbgMemRead) mem_rd_q <= mem[dbgMemAddr[5:2]];
  end

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [95:0] all_outs();
    return {13'd0, holdCpu, busy, done, dbgRegAddr, dbgMemAddr, dbgMemRead,
            outValid, outData, outIsMem, outIndex};
  endfunction

  function automatic logic [95:0] all_outs0();
    return {13'd0, holdCpu0, busy0, done0, dbgRegAddr0, dbgMemAddr0, dbgMemRead0,
            outValid0, outData0, outIsMem0, outIndex0};
  endfunction

  task automatic run_dump(input bit rnd, input int abort_idx);
    int n, n0, cyc, done_cyc, done0_cyc, done_cnt, done0_cnt, addr_n;
    bit hold_ok, stable_ok, prev_stall, prev_rd, fin, mem0_ok;
    logic [40:0] prev_word;
    n = 0; n0 = 0; cyc = 0; done_cyc = -1; done0_cyc = -1;
    done_cnt = 0; done0_cnt = 0; addr_n = 0;
    hold_ok = 1'b1; stable_ok = 1'b1; prev_stall = 1'b0; prev_rd = 1'b0;
    fin = 1'b0; mem0_ok = 1'b1; prev_word = '0;
    @(posedge clk); #1;
    start = 1'b1; abort = 1'b0; outReady = 1'b1;
    while (!fin && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
      // Spurious starts while both blocks are busy, including on the register-only done cycle.
      start = busy && busy0 && ((cyc % 5) == 2 || done0);
      abort = 1'b0;
      outReady = rnd ? ($urandom_range(0, 2) == 0) : 1'b1;
      if (abort_idx >= 0 && outValid && outIsMem && outIndex == 8'(abort_idx)) begin
        abort = 1'b1;
        outReady = 1'b0;
      end
      @(negedge clk);
      if (prev_stall && !(outValid && {outIsMem, outIndex, outData} == prev_word)) stable_ok = 1'b0;
      prev_stall = outValid && !outReady;
      prev_word  = {outIsMem, outIndex, outData};
      if (done_cyc < 0 && !(holdCpu && busy)) hold_ok = 1'b0;
      if (dbgMemRead && !prev_rd) begin
        check($sformatf("mem_addr%0d", addr_n), {64'd0, dbgMemAddr}, 96'(addr_n * 4));
        addr_n++;
      end
      prev_rd = dbgMemRead;
      if (dbgMemRead0 || dbgMemAddr0 != 32'd0) mem0_ok = 1'b0;
      if (outValid && outReady) begin
        if (n < 36) check($sformatf("word%0d", n), {55'd0, outIsMem, outIndex, outData},
                          {55'd0, tbl[n].is_mem, tbl[n].index, tbl[n].dat});
        else check("extra_word", 96'(n), 96'd35);
        n++;
      end
      if (outValid0 && outReady) begin
        if (n0 < 32) check($sformatf("reg_only_word%0d", n0), {55'd0, outIsMem0, outIndex0, outData0},
                           {55'd0, tbl[n0].is_mem, tbl[n0].index, tbl[n0].dat});
        else check("reg_only_extra_word", 96'(n0), 96'd31);
        n0++;
      end
      if (done) begin done_cnt++; if (done_cyc < 0) done_cyc = cyc; end
      if (done0) begin done0_cnt++; if (done0_cyc < 0) done0_cyc = cyc; end
      if (abort) begin
        @(posedge clk); #1;
        abort = 1'b0;
        check("after_abort", {91'd0, busy, holdCpu, outValid, done, dbgMemRead}, 96'd0);
        fin = 1'b1;
      end else if (done_cnt > 0 && done0_cnt > 0) begin
        fin = 1'b1;
      end
    end
    if (!fin) check("dump_timeout", 96'(cyc), 96'd0);
    start = 1'b0;
    outReady = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (done) done_cnt++;
      if (done0) done0_cnt++;
    end
    check("stall_stable", {95'd0, stable_ok}, 96'd1);
    check("hold_busy_during_dump", {95'd0, hold_ok}, 96'd1);
    check("reg_only_no_mem_read", {95'd0, mem0_ok}, 96'd1);
    check("idle_after", {92'd0, busy, holdCpu, busy0, holdCpu0}, 96'd0);
    check("reg_only_done_count", 96'(done0_cnt), 96'd1);
    check("reg_only_word_count", 96'(n0), 96'd32);
    if (abort_idx >= 0) begin
      check("abort_word_count", 96'(n), 96'(32 + abort_idx));
      check("abort_done_count", 96'(done_cnt), 96'd0);
      check("abort_mem_reads", 96'(addr_n), 96'(abort_idx + 1));
    end else begin
      check("word_count", 96'(n), 96'd36);
      check("done_count", 96'(done_cnt), 96'd1);
      check("mem_reads", 96'(addr_n), 96'd4);
    end
    if (!rnd && abort_idx < 0) begin
      check("done_cycle", 96'(done_cyc), 96'd77);
      check("reg_only_done_cycle", 96'(done0_cyc), 96'd65);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int k = 0; k < 32; k++) tbl[k] = '{1'b0, 8'(k), 32'(32'h01010101 * k)};
    tbl[17].dat = 32'h00000005;
    tbl[18].dat = 32'hFFFFFFFD;
    tbl[32] = '{1'b1, 8'd0, 32'h00000000};
    tbl[33] = '{1'b1, 8'd1, 32'hDEADBEEF};
    tbl[34] = '{1'b1, 8'd2, 32'h12345678};
    tbl[35] = '{1'b1, 8'd3, 32'hFFFFFFFF};
    for (int k = 0; k < 32; k++) regs[k] = tbl[k].dat;
    for (int k = 0; k < 16; k++) mem[k] = 32'hA5A50000 + 32'(k);
    for (int k = 0; k < 4; k++) mem[k] = tbl[32 + k].dat;
    mem_rd_q = 32'd0;

    resetN = 1'b0; start = 1'b0; abort = 1'b0; outReady = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", all_outs(), 96'd0);
    check("reset_outputs_reg_only", all_outs0(), 96'd0);
    resetN = 1'b1;

    run_dump(1'b0, -1);
    run_dump(1'b1, -1);

    @(posedge clk); #1;
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    check("start_abort_idle", {94'd0, busy, busy0}, 96'd0);

    run_dump(1'b0, 2);
    run_dump(1'b0, -1);

    // Asynchronous reset for half a cycle while a register word is stalled.
    @(posedge clk); #1;
    start = 1'b1; outReady = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    check("pre_reset_valid", {95'd0, outValid}, 96'd1);
    #1;
    resetN = 1'b0;
    start = 1'b1;
    #1;
    check("async_reset_outputs", all_outs(), 96'd0);
    check("async_reset_outputs_reg_only", all_outs0(), 96'd0);
    #3;
    resetN = 1'b1;
    start = 1'b0;
    @(posedge clk); #1;
    check("post_reset_idle", all_outs(), 96'd0);
    outReady = 1'b1;

    run_dump(1'b0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/machine_state_dumper.md
Name: machine_state_dumper

Overview:
- Post-run read-out engine for the pipelined MIPS core: on a start pulse it takes over the register-file debug read port and the data-memory read port.
- It streams all register contents, then a window of data-memory words, over a valid/ready output channel to the testbench or a host.
- It is the reader counterpart of the instruction-memory program loader. While active it asserts holdCpu so the top level freezes the PC and muxes the debug addresses into the memories.

Parameters:
- NUM_REGS, 32, number of registers dumped, indices 0..NUM_REGS-1; range 1..32.
- MEM_WORDS, 64, number of 32-bit data-memory words dumped; range 0..256; 0 skips the memory phase.
- MEM_BASE, 0, byte address of the first dumped memory word; word-aligned.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- resetN  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a dump; sampled only in IDLE.
- abort  in  1  synchronous cancel; returns the block to IDLE next edge without pulsing done.
- holdCpu  out  1  high from the first cycle after an accepted start until DONE exits.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the final word has been accepted.
- dbgRegAddr  out  5  register-file read address.
- dbgRegData  in  32  register-file read data; combinational from dbgRegAddr.
- dbgMemAddr  out  32  data-memory byte address, equal to MEM_BASE + 4*idx.
- dbgMemRead  out  1  data-memory read enable.
- dbgMemData  in  32  data-memory read data; valid in the cycle after the address and dbgMemRead are first presented.
- outValid  out  1  output word valid.
- outReady  in  1  consumer accepts the word when outValid && outReady.
- outData  out  32  dumped word.
- outIsMem  out  1  0 = register word, 1 = memory word.
- outIndex  out  8  register number, or memory word index from MEM_BASE.

Behaviour:
- Reset values: all outputs 0; state IDLE; idx 0.
- Asynchronous reset mid-dump aborts immediately. No partial done pulse. The stream restarts only on a new start.
- FSM states and transitions:
  - IDLE: start=1 -> REG_FETCH, idx=0.
  - REG_FETCH: dbgRegAddr=idx; on the edge outData<=dbgRegData, outIsMem<=0, outIndex<=idx, outValid<=1 -> REG_OUT.
  - REG_OUT: hold outData, outIsMem, outIndex and outValid stable until handshake.
    - On handshake: outValid<=0.
    - If idx==NUM_REGS-1: idx<=0, then MEM_WORDS>0 -> MEM_ADDR, else -> DONE.
    - Otherwise idx<=idx+1 -> REG_FETCH.
  - MEM_ADDR: dbgMemAddr=MEM_BASE+4*idx, dbgMemRead=1 -> MEM_CAPTURE.
  - MEM_CAPTURE: address and dbgMemRead held; on the edge outData<=dbgMemData, outIsMem<=1, outIndex<=idx, outValid<=1 -> MEM_OUT.
  - MEM_OUT: dbgMemRead=0; on handshake, idx==MEM_WORDS-1 -> DONE, else idx<=idx+1 -> MEM_ADDR.
  - DONE: done=1 for exactly one cycle -> IDLE. holdCpu and busy are low from the following cycle.
- dbgMemRead is never asserted outside MEM_ADDR and MEM_CAPTURE. dbgRegAddr/dbgMemAddr are 0 in IDLE.
- Throughput with outReady tied high:
  - registers: 2 cycles/word;
  - memory: 3 cycles/word;
  - total cycles from start edge to done pulse = 2*NUM_REGS + 3*MEM_WORDS + 1.
- Backpressure: any number of outReady-low cycles. No word is dropped or duplicated, and outData never changes while outValid=1 and outReady=0.
- start while busy is ignored. start and abort together in IDLE: abort wins, stay IDLE.
- abort in any non-IDLE state: next edge IDLE; outValid, holdCpu, busy and dbgMemRead cleared; done not pulsed.
- Address arithmetic is 32-bit modulo; MEM_BASE+4*idx wraps silently.
- The block does not interpret data; register 0 is dumped as whatever the register file returns.

Test Plan:
- Reg dump, ready high, NUM_REGS=32, MEM_WORDS=0.
  - Preload reg k = 0x01010101*k, reg17=5, reg18=0xFFFFFFFD; pulse start.
  - Expect 32 words in order with outIsMem=0, outIndex 0..31, outData matching the preloads.
  - done exactly 65 cycles after start; holdCpu high throughout.
- Memory window, MEM_BASE=0, MEM_WORDS=4.
  - Mem words at byte addresses 0,4,8,12 = 0x0, 0xDEADBEEF, 0x12345678, 0xFFFFFFFF.
  - After the 32 reg words, expect 4 words with outIsMem=1, outIndex 0..3, those values.
  - dbgMemAddr observed 0,4,8,12; done 77 cycles after start.
- Backpressure: outReady toggled with a pseudo-random pattern (≥50% low).
  - Scoreboard shows an identical sequence to the ready-high run.
  - outData/outIndex stable on every stalled cycle; no extra or missing words.
- Abort mid-memory phase at outIndex=2 (memory phase, MEM_WORDS=4).
  - Next cycle busy=0, holdCpu=0, outValid=0, no done pulse.
  - A new start produces the full sequence from reg 0.
- Async reset: drop resetN in REG_OUT for half a cycle.
  - All outputs 0 immediately, independent of clk; start ignored until resetN high.
  - A subsequent dump is correct.
- start pulses during busy and coincident with done: ignored. Exactly one done per accepted start.
